// File: rtl/avg_ram_wr_if.sv
// Bus between the clk_2 FIFO-read controller side and the averaging RAM writer.
// The master drives the read strobes and FIFO byte; the slave (avg_ram_wr)
// returns the RAM write port and status flags.
interface avg_ram_wr_if #(
  parameter int ADDR_W = 11
);
  logic              fifo_rd;
  logic              b1;
  logic              ram_wr;
  logic [7:0]        fifo_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              pass_done;
  logic              seq_err;

  modport master (
    output fifo_rd, b1, ram_wr, fifo_data,
    input  ram_we, ram_addr, ram_din, pass_done, seq_err
  );

  modport slave (
    input  fifo_rd, b1, ram_wr, fifo_data,
    output ram_we, ram_addr, ram_din, pass_done, seq_err
  );
endinterface

// File: rtl/avg_ram_wr.sv
// Averaging RAM writer: sums each group of four FIFO bytes, writes sum/4 to
// the sample RAM at an auto-incrementing, wrapping address and pulses
// pass_done on the write to the last address. A private byte counter watches
// the controller's strobes and raises a sticky seq_err on protocol breaks.
module avg_ram_wr #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input logic         clk_2,
  input logic         reset_n,
  avg_ram_wr_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [9:0]        acc;
  logic [1:0]        bcnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_din_q;
  logic              pass_done_q;
  logic              seq_err_q;

  logic [9:0]        sum;
  logic              write_now;
  logic              err_now;
  logic              at_last;

  // Group sum, write launch and protocol-violation detection for this cycle
  always_comb begin
    sum       = acc + {2'b00, bus.fifo_data};
    write_now = bus.fifo_rd && !bus.ram_wr;
    at_last   = (wr_ptr == LAST_ADDR);
    err_now   = 1'b0;
    if (!bus.ram_wr && !bus.fifo_rd)              err_now = 1'b1;
    if (!bus.ram_wr && bcnt != 2'd3)              err_now = 1'b1;
    if (bus.b1 && bus.fifo_rd && bcnt != 2'd0)    err_now = 1'b1;
    if (bus.b1 && !bus.ram_wr)                    err_now = 1'b1;
  end

  // Accumulate bytes, launch the averaged write on the fourth byte, and keep
  // the sticky error flag; write strobes fall back to zero when idle
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      acc         <= '0;
      bcnt        <= '0;
      wr_ptr      <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= 8'h00;
      pass_done_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      ram_we_q    <= 1'b0;
      pass_done_q <= 1'b0;
      if (err_now) begin
        seq_err_q <= 1'b1;
      end
      if (write_now) begin
        ram_din_q   <= sum[9:2];
        ram_addr_q  <= wr_ptr;
        ram_we_q    <= 1'b1;
        pass_done_q <= at_last;
        bcnt        <= 2'd0;
        wr_ptr      <= at_last ? '0 : wr_ptr + ADDR_W'(1);
      end else if (bus.fifo_rd && bus.b1) begin
        acc  <= {2'b00, bus.fifo_data};
        bcnt <= 2'd1;
      end else if (bus.fifo_rd) begin
        acc  <= sum;
        bcnt <= bcnt + 2'd1;
      end
    end
  end

  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.pass_done = pass_done_q;
  assign bus.seq_err   = seq_err_q;

endmodule

// File: doc/avg_ram_wr.md
# avg_ram_wr

Datapath stage directly downstream of the clk_2 FIFO-read controller. Consumes the controller's `fifo_rd`, `b1` and active-low `ram_wr` strobes plus the FIFO read data. Sums each group of four bytes and writes the truncated average into the sample RAM at an auto-incrementing address, flagging completion of every full RAM pass.

## Interface
- `ADDR_W`, 11 — RAM address width.
- `DEPTH`, 2048 — number of RAM words used; must satisfy 1 <= DEPTH <= 2**ADDR_W. The address wraps after DEPTH-1.
- `clk_2`  in  1 — block clock, the same clock as the FIFO-read controller.
- `reset_n`  in  1 — asynchronous, active-low reset.
- `fifo_rd`  in  1 — controller read strobe; `fifo_data` is valid in the same cycle.
- `b1`  in  1 — high during the read of the first byte of a group.
- `ram_wr`  in  1 — active low; low during the read of the fourth byte of a group.
- `fifo_data`  in  8 — FIFO output byte (show-ahead FIFO).
- `ram_we`  out  1 — RAM write enable, active high, single-cycle pulse.
- `ram_addr`  out  ADDR_W — RAM write address, registered.
- `ram_din`  out  8 — averaged byte, registered.
- `pass_done`  out  1 — one-cycle pulse coincident with the write to address DEPTH-1.
- `seq_err`  out  1 — sticky flag for a protocol violation; cleared only by reset.

## Operation
- Accumulator `acc`, 10 bits wide. Four 8-bit bytes sum to at most 1020, so `acc` never overflows.
- Write pointer `wr_ptr`, ADDR_W bits, range 0..DEPTH-1.
- Byte counter `bcnt`, 2 bits. It tracks the group position independently of the controller and is used only for checking.
- Actions on each `fifo_rd`=1 cycle:
  - `b1`=1: `acc` <= `fifo_data`; `bcnt` <= 1.
  - `b1`=0 and `ram_wr`=1: `acc` <= `acc` + `fifo_data`; `bcnt` <= `bcnt`+1.
  - `ram_wr`=0: compute `sum` = `acc` + `fifo_data` as 10 bits. Then `ram_din` <= `sum`[9:2] (truncating divide by 4), `ram_addr` <= `wr_ptr`, `ram_we` <= 1, `bcnt` <= 0. `wr_ptr` <= 0 if `wr_ptr` == DEPTH-1, else `wr_ptr`+1. `pass_done` <= (`wr_ptr` == DEPTH-1).
- `fifo_rd`=0 cycles: `acc`, `bcnt` and `wr_ptr` hold; `ram_we` and `pass_done` <= 0.
- `ram_we` and `pass_done` are cleared every cycle in which no write is launched.
- `seq_err` is set by any of the following:
  - `ram_wr`=0 while `fifo_rd`=0;
  - `ram_wr`=0 while `bcnt` != 3;
  - `b1`=1 with `fifo_rd`=1 while `bcnt` != 0;
  - `b1`=1 and `ram_wr`=0 in the same cycle.
- Error recovery:
  - A `b1` read always restarts the group, so data resynchronises; the partial sum is discarded.
  - A `ram_wr`=0 with `fifo_rd`=0 performs no write.
  - A `b1`=1 with `ram_wr`=0 is handled as a write of `sum` = `fifo_data` + `acc`, with `b1` ignored.
- `ram_addr` holds its last value between writes. `ram_din` holds its last written value.

## Timing
- Reset values: `acc`=0, `bcnt`=0, `wr_ptr`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0x00, `pass_done`=0, `seq_err`=0. Reset takes effect immediately on `reset_n` falling, with no clock required.
- Latency: if the fourth byte is read in cycle N, then `ram_we`, `ram_addr` and `ram_din` are valid throughout cycle N+1. `ram_we` is high for exactly one cycle.
- Minimum group spacing is 8 cycles, because the controller alternates read and idle. Back-to-back writes are still supported: a write launched in every `ram_wr`=0 cycle produces one `ram_we` cycle each.
- Wrap: the write to DEPTH-1 is followed by a write to address 0. `pass_done` pulses in the same cycle as the DEPTH-1 write.
- Reset asserted mid-group: the partial sum is lost and no write occurs. After release, the next `b1` read starts a fresh group at address 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Group 0x0A, 0x14, 0x1E, 0x28 (b1 on the first byte, ram_wr low on the fourth, idle cycles between) -> one `ram_we` pulse, addr 0, din 0x19; `seq_err`=0.
- Four groups of 0xFF -> din 0xFF at addrs 0..3. Then a group 0x01, 0x01, 0x01, 0x02 -> din 0x01 at addr 4, showing truncation.
- DEPTH=4, five groups -> writes to addrs 0, 1, 2, 3, 0; `pass_done` high only with the addr-3 write.
- Group cut by reset_n low after two bytes; after release, a full group 4, 8, 12, 16 -> single write, din 0x0A, addr 0.
- `b1` reasserted after two bytes, then a full group 0x10×4 -> `seq_err`=1 and stays 1; din 0x10 written at the next address.
- `ram_wr` pulsed low with `fifo_rd`=0 -> no `ram_we`, `wr_ptr` unchanged, `seq_err`=1.
